// File: rtl/run_controller.sv
// Run controller: holds the core in reset, runs it, and stops on PC stall or timeout.
// Optional PC breakpoint termination is compiled in when RUN_CTRL_BREAK_EN is defined.
`timescale 1ns/1ps
module run_controller #(
    parameter int PC_WIDTH       = 16,
    parameter int CNT_WIDTH      = 16,
    parameter int RESET_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int STALL_CYCLES   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [PC_WIDTH-1:0]  pc_i,
`ifdef RUN_CTRL_BREAK_EN
    input  logic                 bp_en_i,
    input  logic [PC_WIDTH-1:0]  bp_addr_i,
    output logic                 bp_hit_o,
`endif
    output logic                 core_reset_o,
    output logic                 run_o,
    output logic [CNT_WIDTH-1:0] cycle_count_o,
    output logic                 done_o,
    output logic                 halted_o,
    output logic                 timed_out_o
);

    localparam int RW = $clog2(RESET_CYCLES + 1);
    localparam int SW = $clog2(STALL_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_e;

    state_e                state_q, state_d;
    logic [RW-1:0]         rstCnt_q, rstCnt_d;
    logic [SW-1:0]         stallCnt_q, stallCnt_d;
    logic [CNT_WIDTH-1:0]  cycleCount_q, cycleCount_d;
    logic [PC_WIDTH-1:0]   prevPc_q, prevPc_d;
    logic                  firstRun_q, firstRun_d;
    logic                  halted_q, halted_d;
    logic                  timedOut_q, timedOut_d;
    logic                  bpHit_q, bpHit_d;
    logic                  coreReset_q, run_q, done_q;
    logic                  pcEqual, haltHit, timeoutHit, bpMatch;

    // The previous PC is meaningless in the first RUN cycle, so equality is masked there.
    assign pcEqual    = (pc_i == prevPc_q) && !firstRun_q;
    assign haltHit    = pcEqual && (stallCnt_q == SW'(STALL_CYCLES - 2));
    assign timeoutHit = (cycleCount_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`ifdef RUN_CTRL_BREAK_EN
    assign bpMatch    = bp_en_i && (pc_i == bp_addr_i);
`else
    assign bpMatch    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        rstCnt_d     = rstCnt_q;
        stallCnt_d   = stallCnt_q;
        cycleCount_d = cycleCount_q;
        prevPc_d     = prevPc_q;
        firstRun_d   = firstRun_q;
        halted_d     = halted_q;
        timedOut_d   = timedOut_q;
        bpHit_d      = bpHit_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d      = RESET;
                    rstCnt_d     = '0;
                    stallCnt_d   = '0;
                    cycleCount_d = '0;
                    halted_d     = 1'b0;
                    timedOut_d   = 1'b0;
                    bpHit_d      = 1'b0;
                end
            end
            RESET: begin
                if (rstCnt_q == RW'(RESET_CYCLES - 1)) begin
                    state_d    = RUN;
                    firstRun_d = 1'b1;
                end else begin
                    rstCnt_d = rstCnt_q + RW'(1);
                end
            end
            RUN: begin
                if (cycleCount_q != '1) begin
                    cycleCount_d = cycleCount_q + CNT_WIDTH'(1);
                end
                prevPc_d   = pc_i;
                firstRun_d = 1'b0;
                stallCnt_d = pcEqual ? stallCnt_q + SW'(1) : '0;
                // Exactly one cause flag: breakpoint beats halt beats timeout.
                if (bpMatch) begin
                    state_d = DONE;
                    bpHit_d = 1'b1;
                end else if (haltHit) begin
                    state_d  = DONE;
                    halted_d = 1'b1;
                end else if (timeoutHit) begin
                    state_d    = DONE;
                    timedOut_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rstCnt_q     <= '0;
            stallCnt_q   <= '0;
            cycleCount_q <= '0;
            prevPc_q     <= '0;
            firstRun_q   <= 1'b0;
            halted_q     <= 1'b0;
            timedOut_q   <= 1'b0;
            bpHit_q      <= 1'b0;
            coreReset_q  <= 1'b1;
            run_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rstCnt_q     <= rstCnt_d;
            stallCnt_q   <= stallCnt_d;
            cycleCount_q <= cycleCount_d;
            prevPc_q     <= prevPc_d;
            firstRun_q   <= firstRun_d;
            halted_q     <= halted_d;
            timedOut_q   <= timedOut_d;
            bpHit_q      <= bpHit_d;
            coreReset_q  <= (state_d == IDLE) || (state_d == RESET);
            run_q        <= (state_d == RUN);
            done_q       <= (state_d == DONE);
        end
    end

    assign core_reset_o  = coreReset_q;
    assign run_o         = run_q;
    assign done_o        = done_q;
    assign cycle_count_o = cycleCount_q;
    assign halted_o      = halted_q;
    assign timed_out_o   = timedOut_q;
`ifdef RUN_CTRL_BREAK_EN
    assign bp_hit_o      = bpHit_q;
`endif

endmodule

// File: tb/tb_run_controller.sv
// Directed testbench for run_controller with default parameters (breakpoint test only when RUN_CTRL_BREAK_EN is defined).
`timescale 1ns/1ps
module tb_run_controller;

    localparam int RC = 2;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [15:0] pc_i;
    logic        core_reset_o;
    logic        run_o;
    logic [15:0] cycle_count_o;
    logic        done_o;
    logic        halted_o;
    logic        timed_out_o;
`ifdef RUN_CTRL_BREAK_EN
    logic        bp_en_i;
    logic [15:0] bp_addr_i;
    logic        bp_hit_o;
`endif

    int vectors = 0;
    int miscompares = 0;

    run_controller dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .pc_i          (pc_i),
`ifdef RUN_CTRL_BREAK_EN
        .bp_en_i       (bp_en_i),
        .bp_addr_i     (bp_addr_i),
        .bp_hit_o      (bp_hit_o),
`endif
        .core_reset_o  (core_reset_o),
        .run_o         (run_o),
        .cycle_count_o (cycle_count_o),
        .done_o        (done_o),
        .halted_o      (halted_o),
        .timed_out_o   (timed_out_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // PC presented in RUN cycle k: 0 inc, 1 hold at 4, 2 hold at 13, 3 inc from 0
    function automatic logic [15:0] pcFor(input int mode, input int k);
        case (mode)
            1:       return 16'(k < 4 ? k : 4);
            2:       return 16'(k < 13 ? k : 13);
            3:       return 16'(k - 1);
            default: return 16'(k);
        endcase
    endfunction

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic startRun();
        pc_i = 16'h0;
        start_i = 1'b1;
        stepClk();
        start_i = 1'b0;
        repeat (RC) stepClk();
    endtask

    task automatic runUntilDone(input int mode, input int budget, output int n);
        n = 0;
        while (!done_o && n < budget) begin
            n++;
            pc_i = pcFor(mode, n);
            stepClk();
        end
    endtask

    task automatic checkEnd(input string name, input logic expHalt, input logic expTo,
                            input logic [15:0] expCnt);
        vectors++;
        if (done_o !== 1'b1 || run_o !== 1'b0 || core_reset_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s_done actual done=%0b run=%0b crst=%0b required 1/0/0", name, done_o, run_o, core_reset_o);
        end
        vectors++;
        if (halted_o !== expHalt || timed_out_o !== expTo) begin
            miscompares++;
            $display("[TB] FAIL %s_cause actual halted=%0b timed_out=%0b required %0b/%0b", name, halted_o, timed_out_o, expHalt, expTo);
        end
        vectors++;
        if (cycle_count_o !== expCnt) begin
            miscompares++;
            $display("[TB] FAIL %s_count actual=%0d required=%0d", name, cycle_count_o, expCnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_i = 1'b0;
        pc_i = 16'h0;
`ifdef RUN_CTRL_BREAK_EN
        bp_en_i = 1'b0;
        bp_addr_i = 16'h0;
`endif
        #1;
        vectors++;
        if (core_reset_o !== 1'b1 || run_o !== 1'b0 || done_o !== 1'b0 || halted_o !== 1'b0 ||
            timed_out_o !== 1'b0 || cycle_count_o !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_values actual crst=%0b run=%0b done=%0b h=%0b to=%0b cnt=%0d required 1/0/0/0/0/0",
                     core_reset_o, run_o, done_o, halted_o, timed_out_o, cycle_count_o);
        end
        repeat (3) stepClk();
        rst = 1'b0;
        repeat (2) stepClk();
        vectors++;
        if (core_reset_o !== 1'b1 || run_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_hold actual crst=%0b run=%0b required 1/0", core_reset_o, run_o);
        end
    endtask

    task automatic test_start_sequence();
        int n;
        start_i = 1'b1;
        stepClk();
        start_i = 1'b0;
        for (int i = 0; i < RC; i++) begin
            vectors++;
            if (core_reset_o !== 1'b1 || run_o !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_phase%0d actual crst=%0b run=%0b required 1/0", i, core_reset_o, run_o);
            end
            if (i < RC - 1) stepClk();
        end
        stepClk();
        vectors++;
        if (core_reset_o !== 1'b0 || run_o !== 1'b1 || cycle_count_o !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL run_entry actual crst=%0b run=%0b cnt=%0d required 0/1/0", core_reset_o, run_o, cycle_count_o);
        end
        for (int k = 1; k <= 3; k++) begin
            pc_i = 16'(k);
            stepClk();
            vectors++;
            if (cycle_count_o !== 16'(k) || run_o !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL count_step%0d actual cnt=%0d run=%0b required %0d/1", k, cycle_count_o, run_o, k);
            end
        end
        runUntilDone(0, 40, n);
        checkEnd("seq_timeout", 1'b0, 1'b1, 16'd16);
    endtask

    task automatic test_timeout();
        int n;
        startRun();
        vectors++;
        if (done_o !== 1'b0 || timed_out_o !== 1'b0 || cycle_count_o !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL restart_clear actual done=%0b to=%0b cnt=%0d required 0/0/0", done_o, timed_out_o, cycle_count_o);
        end
        runUntilDone(0, 40, n);
        checkEnd("timeout", 1'b0, 1'b1, 16'd16);
        repeat (3) stepClk();
        vectors++;
        if (done_o !== 1'b1 || cycle_count_o !== 16'd16 || timed_out_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL done_hold actual done=%0b cnt=%0d to=%0b required 1/16/1", done_o, cycle_count_o, timed_out_o);
        end
    endtask

    task automatic test_halt();
        int n;
        startRun();
        runUntilDone(1, 40, n);
        checkEnd("halt", 1'b1, 1'b0, 16'd7);
    endtask

    task automatic test_halt_vs_timeout();
        int n;
        startRun();
        runUntilDone(2, 40, n);
        checkEnd("halt_vs_to", 1'b1, 1'b0, 16'd16);
    endtask

    task automatic test_back_to_back();
        int n;
        startRun();
        for (int k = 1; k <= 4; k++) begin
            pc_i = 16'(k);
            stepClk();
        end
        pc_i = 16'd5;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (run_o !== 1'b0 || core_reset_o !== 1'b1 || cycle_count_o !== 16'd0 || done_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midrun_rst actual run=%0b crst=%0b cnt=%0d done=%0b required 0/1/0/0",
                     run_o, core_reset_o, cycle_count_o, done_o);
        end
        #2;
        rst = 1'b0;
        stepClk();
        startRun();
        for (int k = 1; k <= 3; k++) begin
            pc_i = 16'(k);
            stepClk();
        end
        start_i = 1'b1;
        pc_i = 16'd4;
        stepClk();
        start_i = 1'b0;
        vectors++;
        if (run_o !== 1'b1 || core_reset_o !== 1'b0 || cycle_count_o !== 16'd4) begin
            miscompares++;
            $display("[TB] FAIL start_in_run actual run=%0b crst=%0b cnt=%0d required 1/0/4", run_o, core_reset_o, cycle_count_o);
        end
        runUntilDone(0, 40, n);
        checkEnd("after_restart", 1'b0, 1'b1, 16'd16);
    endtask

`ifdef RUN_CTRL_BREAK_EN
    task automatic test_breakpoint();
        int n;
        bp_addr_i = 16'h0003;
        bp_en_i = 1'b1;
        startRun();
        runUntilDone(3, 40, n);
        checkEnd("bp", 1'b0, 1'b0, 16'd4);
        vectors++;
        if (bp_hit_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_hit actual=%0b required=1", bp_hit_o);
        end
        bp_en_i = 1'b0;
        startRun();
        runUntilDone(3, 40, n);
        checkEnd("bp_off", 1'b0, 1'b1, 16'd16);
        vectors++;
        if (bp_hit_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_off_hit actual=%0b required=0", bp_hit_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_start_sequence();
        test_timeout();
        test_halt();
        test_halt_vs_timeout();
        test_back_to_back();
`ifdef RUN_CTRL_BREAK_EN
        test_breakpoint();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/run_controller.md
# run_controller

Parametrised run controller for the 16-bit RISC processor simulation and bring-up environment. Replaces the fixed-duration run window with a cycle-accurate FSM: holds the core in reset for a programmable number of cycles, enables it, counts executed cycles, and terminates the run on halt detection (PC stable), on timeout, or, when compiled in, on a PC breakpoint. Sits between the bench/top level and the core's reset and enable inputs.

## Interface
Parameters:
- PC_WIDTH, 16, width of the observed program counter
- CNT_WIDTH, 16, width of the cycle counter
- RESET_CYCLES, 2, cycles `core_reset` is held after `start` (≥1)
- TIMEOUT_CYCLES, 16, maximum RUN cycles before forced stop (≥1, < 2^CNT_WIDTH)
- STALL_CYCLES, 4, consecutive equal-PC samples that signal halt (≥2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin or restart a run
- pc  in  PC_WIDTH  core program counter, sampled each clk
- core_reset  out  1  active-high reset to the core
- run  out  1  core clock enable / run strobe
- cycle_count  out  CNT_WIDTH  RUN cycles elapsed in the current run
- done  out  1  run terminated; held until next `start`
- halted  out  1  termination cause: PC stall
- timed_out  out  1  termination cause: timeout

## Operation
- States: IDLE, RESET, RUN, DONE.
- Reset (`rst`=1): state IDLE, `core_reset`=1, `run`=0, `cycle_count`=0, `done`=`halted`=`timed_out`=0, internal counters 0.
- IDLE: `core_reset`=1, `run`=0. `start`=1 → RESET.
- RESET: `core_reset`=1, `run`=0; reset counter counts RESET_CYCLES cycles, then → RUN. `cycle_count`, flags, stall counter cleared on entry.
- RUN: `core_reset`=0, `run`=1. `cycle_count` increments by 1 each RUN cycle. Previous PC registered each cycle; stall counter increments when `pc` equals previous PC, clears otherwise. Stall counter disregarded in the first RUN cycle (no valid previous PC).
- Halt: stall counter reaches STALL_CYCLES−1 with current `pc` equal to previous (STALL_CYCLES consecutive equal samples) → DONE, `halted`=1.
- Timeout: RUN cycle in which `cycle_count` == TIMEOUT_CYCLES−1 → DONE, `timed_out`=1; `cycle_count` ends at TIMEOUT_CYCLES.
- Priority when simultaneous: breakpoint > halt > timeout; exactly one cause flag set.
- DONE: `done`=1, `run`=0, `core_reset`=0 (core state preserved for inspection), `cycle_count` and flags frozen. `start` → RESET (flags cleared).
- `start` in RESET or RUN: ignored.
- `cycle_count` saturates at all-ones; never wraps.

## Timing
- `start` sampled at edge N → state RESET at N; `core_reset` remains 1 for RESET_CYCLES cycles; `run`=1 from edge N+RESET_CYCLES.
- All outputs registered; `done` and cause flag assert on the same edge that `run` deasserts.
- Terminating RUN cycle is counted in `cycle_count`.
- `rst` asserted mid-run: immediate return to IDLE, outputs to reset values without waiting for a clock edge.

## Configuration
- `RUN_CTRL_BREAK_EN` defined: adds ports `bp_en` (in, 1), `bp_addr` (in, PC_WIDTH), `bp_hit` (out, 1, reset 0). In RUN, `bp_en`=1 and `pc`==`bp_addr` → DONE with `bp_hit`=1 on that edge; highest-priority cause; `cycle_count` includes that cycle.
- Not defined: ports and logic absent; termination only by halt or timeout.

## Test plan
- Reset then `start` pulse, RESET_CYCLES=2 → `core_reset` high exactly 2 cycles after `start`, then `run`=1, `cycle_count` counts 1,2,3…
- PC increments every cycle, TIMEOUT_CYCLES=16 → `done`=1, `timed_out`=1, `halted`=0, `cycle_count`=16, `run`=0 on that edge.
- PC 0,1,2,3 then held at 0x0004, STALL_CYCLES=4 → `halted`=1 once four consecutive samples of 0x0004 observed, `cycle_count`=7, `timed_out`=0.
- Halt and timeout condition on the same cycle (PC stalled from cycle 13, TIMEOUT_CYCLES=16) → only `halted`=1.
- `rst` pulsed at RUN cycle 5 → immediately `run`=0, `core_reset`=1, `cycle_count`=0; new `start` restarts cleanly; `start` during RUN ignored.
- With `RUN_CTRL_BREAK_EN`, `bp_en`=1, `bp_addr`=0x0003, PC incrementing from 0 → `bp_hit`=1, `done`=1, `cycle_count`=4; with `bp_en`=0 run proceeds to timeout.
